// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a single-port, combinational-read SRAM with a registered output word.
// Define SRAM_FIFO_CTRL_ALMOST_EN to add registered almost_full/almost_empty outputs.
module sram_fifo_ctrl #(
  parameter int ADDR  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [ADDR-1:0]  sram_addr,
  output logic [WIDTH-1:0] sram_din,
  output logic             sram_we,
  input  logic [WIDTH-1:0] sram_dout,
`ifdef SRAM_FIFO_CTRL_ALMOST_EN
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    count
`else
  output logic [ADDR:0]    count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} op_e;

  localparam logic [ADDR:0] DepthC = (ADDR+1)'(1) << ADDR;

  logic [ADDR-1:0]  wrPtr_q;
  logic [ADDR-1:0]  rdPtr_q;
  logic [ADDR:0]    count_q;
  logic [ADDR:0]    count_d;
  logic             rdValid_q;
  logic [WIDTH-1:0] rdData_q;
  op_e              lastOp_q;
  op_e              lastOp_d;
  logic             needRd;
  logic             canWr;
  logic             grantWr;
  logic             grantRd;

  // Round-robin between refilling the output register and accepting a write;
  // the previous grant breaks ties so neither side starves.
  always_comb begin
    needRd   = (count_q != '0) && (!rdValid_q || rd_ready);
    canWr    = wr_valid && (count_q != DepthC);
    grantWr  = rst_n && canWr && (!needRd || (lastOp_q == S_RD));
    grantRd  = rst_n && needRd && !grantWr;
    count_d  = count_q;
    lastOp_d = S_IDLE;
    if (grantWr) begin
      count_d  = count_q + (ADDR+1)'(1);
      lastOp_d = S_WR;
    end else if (grantRd) begin
      count_d  = count_q - (ADDR+1)'(1);
      lastOp_d = S_RD;
    end
  end

  assign wr_ready  = grantWr;
  assign sram_we   = grantWr;
  assign sram_addr = grantWr ? wrPtr_q : rdPtr_q;
  assign sram_din  = grantWr ? wr_data : '0;

  assign rd_valid  = rdValid_q;
  assign rd_data   = rdData_q;
  assign count     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      lastOp_q  <= S_IDLE;
    end else begin
      count_q  <= count_d;
      lastOp_q <= lastOp_d;
      if (grantWr) begin
        wrPtr_q <= wrPtr_q + ADDR'(1);
      end
      // A refill takes priority over a pop so a same-cycle pop and refill keeps rd_valid high.
      if (grantRd) begin
        rdPtr_q   <= rdPtr_q + ADDR'(1);
        rdData_q  <= sram_dout;
        rdValid_q <= 1'b1;
      end else if (rdValid_q && rd_ready) begin
        rdValid_q <= 1'b0;
      end
    end
  end

`ifdef SRAM_FIFO_CTRL_ALMOST_EN
  logic almostFull_q;
  logic almostEmpty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almostFull_q  <= 1'b0;
      almostEmpty_q <= 1'b1;
    end else begin
      almostFull_q  <= (count_d >= (DepthC - (ADDR+1)'(1)));
      almostEmpty_q <= (count_d <= (ADDR+1)'(1));
    end
  end

  assign almost_full  = almostFull_q;
  assign almost_empty = almostEmpty_q;
`endif

endmodule
